// File: rtl/tt_um_alu_seq.sv
// Sequential byte ALU: takes operand A with an opcode, then operand B, and
// returns a 16-bit result as two bytes under an rd_ack handshake.
module tt_um_alu_seq (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] WAIT_B = 3'd1;
    localparam logic [2:0] EXEC   = 3'd2;
    localparam logic [2:0] OUT_LO = 3'd3;
    localparam logic [2:0] OUT_HI = 3'd4;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_MUL = 3'd5;
    localparam logic [2:0] OP_SHL = 3'd6;
    localparam logic [2:0] OP_CMP = 3'd7;

    logic [2:0]  state;
    logic [7:0]  a_reg;
    logic [7:0]  b_reg;
    logic [2:0]  op_reg;
    logic [15:0] r_reg;
    logic [2:0]  mul_cnt;

    logic        in_valid;
    logic [2:0]  opcode;
    logic        rd_ack;
    logic        in_ready;
    logic        out_valid;
    logic        out_sel;
    logic [15:0] alu_result;
    logic [15:0] mul_addend;
    logic        unused_ok;

    assign in_valid  = uio_in[0];
    assign opcode    = uio_in[3:1];
    assign rd_ack    = uio_in[4];
    assign unused_ok = &{1'b0, uio_in[7:5]};

    assign in_ready  = (state == IDLE) || (state == WAIT_B);
    assign out_valid = (state == OUT_LO) || (state == OUT_HI);
    assign out_sel   = (state == OUT_HI);

    // Single-cycle operations; MUL is accumulated separately in EXEC.
    always_comb begin
        alu_result = 16'h0000;
        case (op_reg)
            OP_ADD: alu_result = {8'h00, a_reg} + {8'h00, b_reg};
            OP_SUB: begin
                alu_result[7:0]  = a_reg - b_reg;
                alu_result[15:8] = (a_reg < b_reg) ? 8'hFF : 8'h00;
            end
            OP_AND: alu_result = {8'h00, a_reg & b_reg};
            OP_OR:  alu_result = {8'h00, a_reg | b_reg};
            OP_XOR: alu_result = {8'h00, a_reg ^ b_reg};
            OP_SHL: alu_result = {8'h00, a_reg} << b_reg[2:0];
            OP_CMP: alu_result = {13'b0, a_reg > b_reg, a_reg == b_reg, a_reg < b_reg};
            default: alu_result = 16'h0000;
        endcase
    end

    // One bit of B per EXEC cycle: add A shifted by the bit position.
    assign mul_addend = b_reg[mul_cnt] ? ({8'h00, a_reg} << mul_cnt) : 16'h0000;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            a_reg   <= 8'h00;
            b_reg   <= 8'h00;
            op_reg  <= 3'd0;
            r_reg   <= 16'h0000;
            mul_cnt <= 3'd0;
        end else if (ena) begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_reg  <= ui_in;
                        op_reg <= opcode;
                        state  <= WAIT_B;
                    end
                end
                WAIT_B: begin
                    if (in_valid) begin
                        b_reg   <= ui_in;
                        r_reg   <= 16'h0000;
                        mul_cnt <= 3'd0;
                        state   <= EXEC;
                    end
                end
                EXEC: begin
                    if (op_reg == OP_MUL) begin
                        r_reg   <= r_reg + mul_addend;
                        mul_cnt <= mul_cnt + 3'd1;
                        if (mul_cnt == 3'd7) begin
                            state <= OUT_LO;
                        end
                    end else begin
                        r_reg <= alu_result;
                        state <= OUT_LO;
                    end
                end
                OUT_LO: begin
                    if (rd_ack) begin
                        state <= OUT_HI;
                    end
                end
                OUT_HI: begin
                    if (rd_ack) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign uo_out  = (state == OUT_LO) ? r_reg[7:0] :
                     (state == OUT_HI) ? r_reg[15:8] : 8'h00;
    assign uio_out = {out_sel, out_valid, in_ready, 5'b00000};
    assign uio_oe  = 8'hE0;

endmodule

// File: tb/tb_tt_um_alu_seq.sv
// Self-checking bench for tt_um_alu_seq: vector table, scoreboard queue of
// expected result bytes, and hand sequences for reset and ena corner cases.
module tb_tt_um_alu_seq;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int n_cmp;
    int n_fail;

    logic [7:0] exp_q[$];

    typedef struct {
        logic [7:0] a;
        logic [2:0] op;
        logic [7:0] b;
        logic [7:0] lo;
        logic [7:0] hi;
    } vec_t;

    vec_t vecs[14];

    tt_um_alu_seq dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uio_in  (uio_in),
        .uo_out  (uo_out),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout, want completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    // Bench-side reference for randomised vectors.
    function automatic logic [15:0] model(input logic [7:0] a, input logic [2:0] op, input logic [7:0] b);
        logic [15:0] wa;
        logic [15:0] wb;
        wa = {8'h00, a};
        wb = {8'h00, b};
        case (op)
            3'd0: return wa + wb;
            3'd1: return {(a < b) ? 8'hFF : 8'h00, 8'(a - b)};
            3'd2: return wa & wb;
            3'd3: return wa | wb;
            3'd4: return wa ^ wb;
            3'd5: return wa * wb;
            3'd6: return wa << b[2:0];
            default: return {13'b0, a > b, a == b, a < b};
        endcase
    endfunction

    // Presents A/op then B (with junk opcode and rd_ack during B) and queues the expected bytes.
    task automatic applyStimulus(input logic [7:0] a, input logic [2:0] op, input logic [7:0] b,
                                 input logic [7:0] lo, input logic [7:0] hi);
        checkOutput("in_ready_idle", {15'b0, uio_out[5]}, 16'h1);
        ui_in  = a;
        uio_in = {3'b101, 1'b0, op, 1'b1};
        step();
        checkOutput("in_ready_wait_b", {15'b0, uio_out[5]}, 16'h1);
        ui_in  = b;
        uio_in = {3'b010, 1'b1, ~op, 1'b1};
        step();
        uio_in = 8'h00;
        ui_in  = 8'hA5;
        exp_q.push_back(lo);
        exp_q.push_back(hi);
    endtask

    task automatic wait_result(input int exp_lat, input int gap_at, input int gap_len);
        int cycles;
        cycles = 0;
        checkOutput("exec_uo_out", {8'h00, uo_out}, 16'h0000);
        while (uio_out[6] == 1'b0 && cycles < 40) begin
            checkOutput("exec_in_ready", {15'b0, uio_out[5]}, 16'h0);
            if (cycles == gap_at) ena = 1'b0;
            if (cycles == gap_at + gap_len) ena = 1'b1;
            step();
            cycles++;
        end
        ena = 1'b1;
        checkOutput("latency", 16'(cycles), 16'(exp_lat));
    endtask

    task automatic pop_expected(output logic [7:0] v);
        if (exp_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("[TB] FAIL scoreboard: got empty queue, want entry");
            v = 8'hXX;
        end else begin
            v = exp_q.pop_front();
        end
    endtask

    task automatic readResult();
        logic [7:0] e;
        checkOutput("lo_out_valid", {15'b0, uio_out[6]}, 16'h1);
        checkOutput("lo_out_sel", {15'b0, uio_out[7]}, 16'h0);
        pop_expected(e);
        checkOutput("lo_byte", {8'h00, uo_out}, {8'h00, e});
        uio_in = 8'h10;
        step();
        checkOutput("hi_out_valid", {15'b0, uio_out[6]}, 16'h1);
        checkOutput("hi_out_sel", {15'b0, uio_out[7]}, 16'h1);
        pop_expected(e);
        checkOutput("hi_byte", {8'h00, uo_out}, {8'h00, e});
        step();
        uio_in = 8'h00;
        checkOutput("idle_uio_out", {8'h00, uio_out}, 16'h0020);
        checkOutput("idle_uo_out", {8'h00, uo_out}, 16'h0000);
    endtask

    initial begin
        logic [7:0]  ra;
        logic [7:0]  rb;
        logic [2:0]  rop;
        logic [15:0] rexp;

        n_cmp  = 0;
        n_fail = 0;
        rst_n  = 1'b0;
        ena    = 1'b1;
        ui_in  = 8'h00;
        uio_in = 8'h00;

        vecs[0]  = '{8'hF0, 3'd0, 8'h20, 8'h10, 8'h01};
        vecs[1]  = '{8'hFF, 3'd5, 8'hFF, 8'h01, 8'hFE};
        vecs[2]  = '{8'h05, 3'd1, 8'h07, 8'hFE, 8'hFF};
        vecs[3]  = '{8'h10, 3'd7, 8'h10, 8'h02, 8'h00};
        vecs[4]  = '{8'h81, 3'd6, 8'h03, 8'h08, 8'h04};
        vecs[5]  = '{8'hF0, 3'd2, 8'h3C, 8'h30, 8'h00};
        vecs[6]  = '{8'hF0, 3'd3, 8'h0F, 8'hFF, 8'h00};
        vecs[7]  = '{8'hAA, 3'd4, 8'hFF, 8'h55, 8'h00};
        vecs[8]  = '{8'h07, 3'd1, 8'h05, 8'h02, 8'h00};
        vecs[9]  = '{8'h20, 3'd7, 8'h10, 8'h04, 8'h00};
        vecs[10] = '{8'h05, 3'd7, 8'h06, 8'h01, 8'h00};
        vecs[11] = '{8'h0D, 3'd5, 8'h0B, 8'h8F, 8'h00};
        vecs[12] = '{8'hFF, 3'd0, 8'h01, 8'h00, 8'h01};
        vecs[13] = '{8'h01, 3'd6, 8'h0F, 8'h80, 8'h00};

        #12;
        checkOutput("reset_uo_out", {8'h00, uo_out}, 16'h0000);
        checkOutput("reset_uio_out", {8'h00, uio_out}, 16'h0020);
        checkOutput("reset_uio_oe", {8'h00, uio_oe}, 16'h00E0);
        step();
        rst_n = 1'b1;
        step();

        $display("[TB] vector table");
        for (int i = 0; i < 14; i++) begin
            applyStimulus(vecs[i].a, vecs[i].op, vecs[i].b, vecs[i].lo, vecs[i].hi);
            wait_result((vecs[i].op == 3'd5) ? 8 : 1, -1, 0);
            readResult();
        end

        $display("[TB] ena gating and in_valid in OUT_LO");
        applyStimulus(8'h12, 3'd0, 8'h34, 8'h46, 8'h00);
        wait_result(1, -1, 0);
        ena    = 1'b0;
        uio_in = 8'h10;
        step();
        step();
        checkOutput("ena0_out_sel", {15'b0, uio_out[7]}, 16'h0);
        checkOutput("ena0_uo_out", {8'h00, uo_out}, 16'h0046);
        ena    = 1'b1;
        ui_in  = 8'h99;
        uio_in = 8'h0B;
        step();
        uio_in = 8'h00;
        checkOutput("inval_out_sel", {15'b0, uio_out[7]}, 16'h0);
        checkOutput("inval_uo_out", {8'h00, uo_out}, 16'h0046);
        readResult();

        $display("[TB] MUL with ena low for 3 cycles");
        applyStimulus(8'hFF, 3'd5, 8'hFF, 8'h01, 8'hFE);
        wait_result(11, 3, 3);
        readResult();

        $display("[TB] reset mid-MUL");
        applyStimulus(8'hFF, 3'd5, 8'hFF, 8'h01, 8'hFE);
        step();
        step();
        step();
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_uo_out", {8'h00, uo_out}, 16'h0000);
        checkOutput("midrst_uio_out", {8'h00, uio_out}, 16'h0020);
        exp_q.delete();
        step();
        rst_n = 1'b1;
        step();
        applyStimulus(8'h01, 3'd0, 8'h01, 8'h02, 8'h00);
        wait_result(1, -1, 0);
        readResult();

        $display("[TB] random back-to-back vectors");
        for (int i = 0; i < 8; i++) begin
            ra   = 8'($urandom_range(0, 255));
            rb   = 8'($urandom_range(0, 255));
            rop  = 3'($urandom_range(0, 7));
            rexp = model(ra, rop, rb);
            applyStimulus(ra, rop, rb, rexp[7:0], rexp[15:8]);
            wait_result((rop == 3'd5) ? 8 : 1, -1, 0);
            readResult();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
